// File: rtl/snappy_job_dispatcher.sv
// Snappy job dispatcher: loads one descriptor per decompressor slot, pads unused slots, starts the batch, waits for completion.
// Latency: a descriptor accepted on edge t appears as a job load on cycle t+1; start follows the last job load by one cycle.
// Backpressure: desc_ready is high only while loading; descriptors are held off for the rest of the batch.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   desc_*                host descriptor stream (valid/ready handshake, desc_last closes a batch early)
//   job_valid, job_id,    one-cycle job load strobe and its fields to the IO controller
//   src_addr, des_addr, compression_length, decompression_length
//   dec_active            per-slot flag, 1 = slot holds a real (non-pad) job
//   start, idle           batch start pulse out, IO controller idle in
//   batch_done            one-cycle pulse when a batch completes
//   batch_count           completed batch counter (wraps)
module snappy_job_dispatcher #(
  parameter int NUM_DECOMPRESSOR = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        desc_valid,
  output logic                        desc_ready,
  input  logic [63:0]                 desc_src_addr,
  input  logic [63:0]                 desc_des_addr,
  input  logic [34:0]                 desc_comp_len,
  input  logic [31:0]                 desc_decomp_len,
  input  logic                        desc_last,
  output logic                        job_valid,
  output logic [15:0]                 job_id,
  output logic [63:0]                 src_addr,
  output logic [63:0]                 des_addr,
  output logic [34:0]                 compression_length,
  output logic [31:0]                 decompression_length,
  output logic [NUM_DECOMPRESSOR-1:0] dec_active,
  output logic                        start,
  input  logic                        idle,
  output logic                        batch_done,
  output logic [31:0]                 batch_count
);

  localparam logic [5:0]                  LAST_SLOT = 6'(NUM_DECOMPRESSOR - 1);
  localparam logic [NUM_DECOMPRESSOR-1:0] SLOT0     = NUM_DECOMPRESSOR'(1);

  // Pad jobs request one minimal 64 B burst so the IO controller never sees a zero length.
  localparam logic [34:0] PAD_COMP_LEN   = 35'd64;
  localparam logic [31:0] PAD_DECOMP_LEN = 32'd64;

  typedef enum logic [2:0] {
    LOAD,
    PAD,
    START,
    RUN_WAIT_BUSY,
    RUN_WAIT_IDLE,
    DONE
  } state_t;

  state_t                      state, state_nxt;
  logic [5:0]                  slot, slot_nxt;
  logic [NUM_DECOMPRESSOR-1:0] active_nxt;
  logic                        issue;       // a job load goes out next cycle
  logic                        issue_real;  // ... and it carries the accepted descriptor
  logic                        accept;

  // desc_ready is a flop that is only ever 1 while the FSM sits in LOAD.
  assign accept = desc_valid & desc_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    active_nxt = dec_active;
    issue      = 1'b0;
    issue_real = 1'b0;
    case (state)
      LOAD: begin
        if (accept) begin
          issue      = 1'b1;
          issue_real = 1'b1;
          active_nxt = dec_active | (SLOT0 << slot);
          slot_nxt   = slot + 6'd1;
          // A full batch wins over desc_last, so a last on the final slot is an ordinary fill.
          if (slot == LAST_SLOT) begin
            state_nxt = START;
          end else if (desc_last) begin
            state_nxt = PAD;
          end
        end
      end
      PAD: begin
        issue    = 1'b1;
        slot_nxt = slot + 6'd1;
        if (slot == LAST_SLOT) begin
          state_nxt = START;
        end
      end
      // START is occupied while the final job load is on the bus; start itself goes out next cycle.
      START:         state_nxt = RUN_WAIT_BUSY;
      // Idle is still high from before the batch; wait for the controller to pick up the work first.
      RUN_WAIT_BUSY: if (!idle) state_nxt = RUN_WAIT_IDLE;
      RUN_WAIT_IDLE: if (idle) state_nxt = DONE;
      DONE: begin
        state_nxt  = LOAD;
        slot_nxt   = '0;
        active_nxt = '0;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot                 <= '0;
      dec_active           <= '0;
      desc_ready           <= 1'b0;
      job_valid            <= 1'b0;
      job_id               <= '0;
      src_addr             <= '0;
      des_addr             <= '0;
      compression_length   <= '0;
      decompression_length <= '0;
      start                <= 1'b0;
      batch_done           <= 1'b0;
      batch_count          <= '0;
    end else begin
      slot       <= slot_nxt;
      dec_active <= active_nxt;
      desc_ready <= (state_nxt == LOAD);
      job_valid  <= issue;
      start      <= (state == START);
      batch_done <= (state_nxt == DONE);
      if (state_nxt == DONE) begin
        batch_count <= batch_count + 32'd1;
      end
      // Job fields hold their last value between loads; only job_valid qualifies them.
      if (issue) begin
        job_id <= {10'd0, slot};
        if (issue_real) begin
          src_addr             <= desc_src_addr;
          des_addr             <= desc_des_addr;
          compression_length   <= desc_comp_len;
          decompression_length <= desc_decomp_len;
        end else begin
          src_addr             <= '0;
          des_addr             <= '0;
          compression_length   <= PAD_COMP_LEN;
          decompression_length <= PAD_DECOMP_LEN;
        end
      end
    end
  end

endmodule

// File: tb/tb_snappy_job_dispatcher.sv
// Testbench for snappy_job_dispatcher with four decompressor slots.
// A transaction-level model predicts every output each cycle; a few literal checks pin the model.
module tb_snappy_job_dispatcher;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          desc_valid;
  logic          desc_ready;
  logic [63:0]   desc_src_addr;
  logic [63:0]   desc_des_addr;
  logic [34:0]   desc_comp_len;
  logic [31:0]   desc_decomp_len;
  logic          desc_last;
  logic          job_valid;
  logic [15:0]   job_id;
  logic [63:0]   src_addr;
  logic [63:0]   des_addr;
  logic [34:0]   compression_length;
  logic [31:0]   decompression_length;
  logic [N-1:0]  dec_active;
  logic          start;
  logic          idle;
  logic          batch_done;
  logic [31:0]   batch_count;

  snappy_job_dispatcher #(.NUM_DECOMPRESSOR(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src_addr(desc_src_addr), .desc_des_addr(desc_des_addr),
    .desc_comp_len(desc_comp_len), .desc_decomp_len(desc_decomp_len),
    .desc_last(desc_last),
    .job_valid(job_valid), .job_id(job_id),
    .src_addr(src_addr), .des_addr(des_addr),
    .compression_length(compression_length), .decompression_length(decompression_length),
    .dec_active(dec_active), .start(start), .idle(idle),
    .batch_done(batch_done), .batch_count(batch_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_note(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] id;
    logic [63:0] src;
    logic [63:0] des;
    logic [34:0] comp;
    logic [31:0] decomp;
  } job_t;

  typedef enum int {P_ACCEPT, P_DRAIN, P_BUSY, P_IDLE, P_DONE} phase_t;

  job_t         pend[$];             // job loads still to appear, one per cycle
  phase_t       phase     = P_ACCEPT;
  int           m_filled  = 0;
  logic [N-1:0] m_active  = '0;
  logic [31:0]  m_count   = '0;
  logic         exp_ready = 1'b0;
  logic         exp_jv    = 1'b0;
  logic         exp_start = 1'b0;
  logic         exp_done  = 1'b0;
  job_t         exp_job   = '{16'd0, 64'd0, 64'd0, 35'd0, 32'd0};

  always @(negedge clk) begin
    logic n_ready, n_jv, n_start, n_done;
    job_t n_job;
    if (!rst_n) begin
      pend.delete();
      phase     = P_ACCEPT;
      m_filled  = 0;
      m_active  = '0;
      m_count   = '0;
      exp_ready = 1'b0;
      exp_jv    = 1'b0;
      exp_start = 1'b0;
      exp_done  = 1'b0;
      exp_job   = '{16'd0, 64'd0, 64'd0, 35'd0, 32'd0};
    end

    // compare this cycle
    check("desc_ready", 64'(desc_ready), 64'(exp_ready));
    check("job_valid", 64'(job_valid), 64'(exp_jv));
    check("start", 64'(start), 64'(exp_start));
    check("batch_done", 64'(batch_done), 64'(exp_done));
    check("dec_active", 64'(dec_active), 64'(m_active));
    check("batch_count", 64'(batch_count), 64'(m_count));
    if (exp_jv || !rst_n) begin
      check("job_id", 64'(job_id), 64'(exp_job.id));
      check("src_addr", src_addr, exp_job.src);
      check("des_addr", des_addr, exp_job.des);
      check("compression_length", 64'(compression_length), 64'(exp_job.comp));
      check("decompression_length", 64'(decompression_length), 64'(exp_job.decomp));
    end

    // predict next cycle from the inputs the coming edge will sample
    n_ready = 1'b0;
    n_jv    = 1'b0;
    n_start = 1'b0;
    n_done  = 1'b0;
    n_job   = exp_job;
    case (phase)
      P_ACCEPT: begin
        n_ready = 1'b1;
        if (exp_ready && desc_valid) begin
          pend.push_back('{16'(m_filled), desc_src_addr, desc_des_addr, desc_comp_len, desc_decomp_len});
          m_active[m_filled] = 1'b1;
          m_filled++;
          if (m_filled == N || desc_last) begin
            while (m_filled < N) begin
              pend.push_back('{16'(m_filled), 64'd0, 64'd0, 35'd64, 32'd64});
              m_filled++;
            end
            phase   = P_DRAIN;
            n_ready = 1'b0;
          end
        end
      end
      P_DRAIN: begin
        if (pend.size() == 0) begin
          n_start = 1'b1;
          phase   = P_BUSY;
        end
      end
      P_BUSY: if (!idle) phase = P_IDLE;
      P_IDLE: begin
        if (idle) begin
          n_done  = 1'b1;
          m_count = m_count + 32'd1;
          phase   = P_DONE;
        end
      end
      P_DONE: begin
        m_active = '0;
        m_filled = 0;
        n_ready  = 1'b1;
        phase    = P_ACCEPT;
      end
      default: phase = P_ACCEPT;
    endcase
    if (pend.size() > 0) begin
      n_jv  = 1'b1;
      n_job = pend.pop_front();
    end
    exp_ready = n_ready;
    exp_jv    = n_jv;
    exp_start = n_start;
    exp_done  = n_done;
    exp_job   = n_job;
  end

  // ---------------- stimulus ----------------
  // Called and returning at posedge+2; on return the job load of this descriptor is visible.
  task automatic send_desc(input logic [63:0] s, input logic [63:0] d, input logic [34:0] cl,
                           input logic [31:0] dl, input logic last);
    logic acc;
    int   g;
    desc_valid      = 1'b1;
    desc_src_addr   = s;
    desc_des_addr   = d;
    desc_comp_len   = cl;
    desc_decomp_len = dl;
    desc_last       = last;
    g = 0;
    acc = 1'b0;
    while (!acc && g < 300) begin
      @(negedge clk);
      acc = desc_ready;
      @(posedge clk);
      #2;
      g++;
    end
    if (!acc) fail_note("desc_accept_timeout");
    desc_valid = 1'b0;
    desc_last  = 1'b0;
  endtask

  // Returns at the negedge of the cycle where start is high.
  task automatic wait_start();
    int g;
    g = 0;
    @(negedge clk);
    while (!start && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!start) fail_note("start_timeout");
  endtask

  // Emulates the IO controller: idle high for hi cycles after start, low for busy cycles, then high.
  task automatic run_idle(input int hi, input int busy);
    int g;
    repeat (hi) @(posedge clk);
    #2 idle = 1'b0;
    repeat (busy) @(posedge clk);
    #2 idle = 1'b1;
    g = 0;
    while (!batch_done && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!batch_done) fail_note("batch_done_timeout");
    @(posedge clk);
    #2;
  endtask

  task automatic random_batch();
    logic last;
    for (int i = 0; i < N; i++) begin
      last = ($urandom_range(0, 2) == 0);
      send_desc({$urandom, $urandom}, {$urandom, $urandom}, 35'({$urandom, $urandom}), $urandom, last);
      if (last) break;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #2;
      end
    end
    wait_start();
    run_idle($urandom_range(1, 4), $urandom_range(1, 10));
  endtask

  initial begin
    rst_n           = 1'b0;
    desc_valid      = 1'b0;
    desc_src_addr   = '0;
    desc_des_addr   = '0;
    desc_comp_len   = '0;
    desc_decomp_len = '0;
    desc_last       = 1'b0;
    idle            = 1'b1;

    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("lit_ready_after_reset", 64'(desc_ready), 64'd1);
    check("lit_count_after_reset", 64'(batch_count), 64'd0);
    @(posedge clk);
    #2;

    // Full batch, back-to-back descriptors.
    send_desc(64'h1000, 64'h2000_0000, 35'd5000, 32'd12000, 1'b0);
    check("lit_a0_valid", 64'(job_valid), 64'd1);
    check("lit_a0_id", 64'(job_id), 64'd0);
    check("lit_a0_src", src_addr, 64'h1000);
    check("lit_a0_comp", 64'(compression_length), 64'd5000);
    send_desc(64'h9000, 64'h3000_0000, 35'd64, 32'd64, 1'b0);
    check("lit_a1_id", 64'(job_id), 64'd1);
    check("lit_a1_src", src_addr, 64'h9000);
    check("lit_a1_comp", 64'(compression_length), 64'd64);
    send_desc(64'hA000, 64'h4000_0000, 35'd0, 32'd0, 1'b0);
    send_desc(64'hB000, 64'h5000_0000, 35'h4_0000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_start();
    check("lit_a_active", 64'(dec_active), 64'hF);
    run_idle(2, 100);
    check("lit_a_count", 64'(batch_count), 64'd1);
    check("lit_a_ready_after_done", 64'(desc_ready), 64'd1);

    // Single descriptor with desc_last: three pad slots.
    send_desc(64'h5000, 64'h6000, 35'd300, 32'd900, 1'b1);
    check("lit_b0_id", 64'(job_id), 64'd0);
    check("lit_b0_src", src_addr, 64'h5000);
    @(posedge clk);
    #2;
    check("lit_b1_valid", 64'(job_valid), 64'd1);
    check("lit_b1_id", 64'(job_id), 64'd1);
    check("lit_b1_comp", 64'(compression_length), 64'd64);
    check("lit_b1_decomp", 64'(decompression_length), 64'd64);
    check("lit_b1_src", src_addr, 64'd0);
    wait_start();
    check("lit_b_active", 64'(dec_active), 64'h1);
    // Descriptor offered during the run must wait; idle stays high 3 cycles after start.
    desc_valid      = 1'b1;
    desc_src_addr   = 64'hABCD_0000;
    desc_des_addr   = 64'h1234_0000;
    desc_comp_len   = 35'd777;
    desc_decomp_len = 32'd2048;
    desc_last       = 1'b0;
    run_idle(3, 20);
    check("lit_b_count", 64'(batch_count), 64'd2);
    send_desc(64'hABCD_0000, 64'h1234_0000, 35'd777, 32'd2048, 1'b0);
    check("lit_held_id", 64'(job_id), 64'd0);
    check("lit_held_src", src_addr, 64'hABCD_0000);
    send_desc(64'hC000, 64'hD000, 35'd128, 32'd256, 1'b1);
    wait_start();
    check("lit_c_active", 64'(dec_active), 64'h3);
    run_idle(1, 5);

    for (int b = 0; b < 25; b++) random_batch();

    // Asynchronous reset while waiting for idle.
    for (int i = 0; i < N; i++)
      send_desc({$urandom, $urandom}, {$urandom, $urandom}, 35'd4096, 32'd8192, 1'b0);
    wait_start();
    @(posedge clk);
    #2 idle = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("lit_rst_ready", 64'(desc_ready), 64'd0);
    check("lit_rst_jv", 64'(job_valid), 64'd0);
    check("lit_rst_id", 64'(job_id), 64'd0);
    check("lit_rst_src", src_addr, 64'd0);
    check("lit_rst_des", des_addr, 64'd0);
    check("lit_rst_comp", 64'(compression_length), 64'd0);
    check("lit_rst_decomp", 64'(decompression_length), 64'd0);
    check("lit_rst_active", 64'(dec_active), 64'd0);
    check("lit_rst_start", 64'(start), 64'd0);
    check("lit_rst_done", 64'(batch_done), 64'd0);
    check("lit_rst_count", 64'(batch_count), 64'd0);
    idle = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("lit_post_rst_ready", 64'(desc_ready), 64'd1);
    check("lit_post_rst_count", 64'(batch_count), 64'd0);
    @(posedge clk);
    #2;
    random_batch();
    random_batch();
    check("lit_final_count", 64'(batch_count), 64'd2);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
